// File: rtl/dac_update_scheduler.sv
// Sample-rate sequencer for the AD5541 SPI DAC path: sample FIFO, tick generator, launch/LDAC FSM.
// Build option DAC_LDAC_SYNC_EN adds the LDAC strobe state; without it ldac_n is tied low.
//
// state     | meaning
// ----------+----------------------------------------------------------
// S_IDLE    | waiting for a sample tick; empty FIFO at tick -> underrun
// S_LAUNCH  | pop FIFO head into spi_data, spi_start pulses next cycle
// S_WAIT_HI | waiting for the SPI master to raise busy
// S_WAIT_LO | waiting for the SPI master to drop busy
// S_LDAC    | ldac_n held low for LDAC_W cycles (DAC_LDAC_SYNC_EN only)

module dac_update_scheduler #(
  parameter int FIFO_DEPTH = 16,
  parameter int PERIOD_W   = 16,
  parameter int LDAC_W     = 4
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic                        enable,
  input  logic [PERIOD_W-1:0]         period,
  input  logic                        s_valid,
  output logic                        s_ready,
  input  logic [15:0]                 s_data,
  output logic                        spi_start,
  output logic [15:0]                 spi_data,
  input  logic                        spi_busy,
  output logic                        ldac_n,
  output logic [$clog2(FIFO_DEPTH):0] fifo_count,
  output logic                        underrun,
  output logic                        late,
  input  logic                        flags_clr,
  output logic                        active
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam logic [AW:0] FULL = (AW+1)'(FIFO_DEPTH);

  if (FIFO_DEPTH < 2 || FIFO_DEPTH > 256 || (1 << AW) != FIFO_DEPTH) begin : g_bad_depth
    $error("FIFO_DEPTH must be a power of two in 2..256");
  end
  if (LDAC_W < 1 || LDAC_W > 15) begin : g_bad_ldac_w
    $error("LDAC_W must be in 1..15");
  end

`ifdef DAC_LDAC_SYNC_EN
  typedef enum logic [2:0] {S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO, S_LDAC} state_t;
`else
  typedef enum logic [1:0] {S_IDLE, S_LAUNCH, S_WAIT_HI, S_WAIT_LO} state_t;
`endif

  state_t              state, state_nxt;
  logic [PERIOD_W-1:0] tick_cnt, last_cnt;
  logic                tick;
  logic [15:0]         mem [FIFO_DEPTH];
  logic [AW-1:0]       wr_ptr, rd_ptr;
  logic                push, pop, empty;
  logic                set_underrun, set_late;

  // Periods 0 and 1 behave as 2; >= lets a shrinking period tick immediately.
  assign last_cnt = (period[PERIOD_W-1:1] == '0) ? PERIOD_W'(1) : period - PERIOD_W'(1);
  assign tick     = enable && (tick_cnt >= last_cnt);

  always_ff @(posedge clk) begin
    if (rst || !enable) tick_cnt <= '0;
    else if (tick)      tick_cnt <= '0;
    else                tick_cnt <= tick_cnt + 1'b1;
  end

  assign s_ready = (fifo_count != FULL);
  assign empty   = (fifo_count == '0);
  // A pop frees the head slot in the same cycle, so a full FIFO still takes the word.
  assign push    = s_valid && (s_ready || pop);

  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      fifo_count <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + 1'b1;
      if (pop)  rd_ptr <= rd_ptr + 1'b1;
      if (push && !pop)      fifo_count <= fifo_count + 1'b1;
      else if (pop && !push) fifo_count <= fifo_count - 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= s_data;
  end

`ifdef DAC_LDAC_SYNC_EN
  localparam logic [3:0] LDAC_LAST = 4'(LDAC_W - 1);
  logic [3:0] ldac_cnt;
`endif

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt    = state;
    pop          = 1'b0;
    set_underrun = 1'b0;
    set_late     = tick && (state != S_IDLE);
    case (state)
      S_IDLE: begin
        if (tick) begin
          if (empty) set_underrun = 1'b1;
          else       state_nxt    = S_LAUNCH;
        end
      end
      S_LAUNCH: begin
        pop       = 1'b1;
        state_nxt = S_WAIT_HI;
      end
      S_WAIT_HI: begin
        if (spi_busy) state_nxt = S_WAIT_LO;
      end
      S_WAIT_LO: begin
        if (!spi_busy) begin
`ifdef DAC_LDAC_SYNC_EN
          state_nxt = S_LDAC;
`else
          state_nxt = S_IDLE;
`endif
        end
      end
`ifdef DAC_LDAC_SYNC_EN
      S_LDAC: begin
        if (ldac_cnt == '0) state_nxt = S_IDLE;
      end
`endif
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      spi_start <= 1'b0;
      spi_data  <= '0;
      underrun  <= 1'b0;
      late      <= 1'b0;
    end else begin
      spi_start <= pop;
      if (pop) spi_data <= mem[rd_ptr];
      if (set_underrun)   underrun <= 1'b1;
      else if (flags_clr) underrun <= 1'b0;
      if (set_late)       late <= 1'b1;
      else if (flags_clr) late <= 1'b0;
    end
  end

`ifdef DAC_LDAC_SYNC_EN
  always_ff @(posedge clk) begin
    if (rst) begin
      ldac_cnt <= '0;
      ldac_n   <= 1'b1;
    end else begin
      if (state == S_WAIT_LO && state_nxt == S_LDAC) ldac_cnt <= LDAC_LAST;
      else if (state == S_LDAC && ldac_cnt != '0)    ldac_cnt <= ldac_cnt - 1'b1;
      ldac_n <= (state_nxt != S_LDAC);
    end
  end
`else
  // DAC configured for immediate update on CS rise.
  assign ldac_n = 1'b0;
`endif

  assign active = (state != S_IDLE);

endmodule

// File: tb/tb_dac_update_scheduler.sv
// Directed bench for dac_update_scheduler with a simple SPI busy model and launch/LDAC monitor.
module tb_dac_update_scheduler;
  localparam int DEPTH = 16;
`ifdef DAC_LDAC_SYNC_EN
  localparam logic LDAC_IDLE = 1'b1;
`else
  localparam logic LDAC_IDLE = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst, enable, s_valid, s_ready, spi_start, spi_busy, ldac_n;
  logic        underrun, late, flags_clr, active;
  logic [15:0] period, s_data, spi_data;
  logic [4:0]  fifo_count;

  int n_checks = 0;
  int n_fail   = 0;
  int cyc      = 0;
  int busy_len = 40;
  int busy_cnt = 0;
  int ldac_low = 0;
  int ldac_high = 0;
  logic ldac_prev = LDAC_IDLE;
  int start_cyc[$];
  logic [15:0] start_dat[$];
  int fall_cyc[$];

  dac_update_scheduler #(.FIFO_DEPTH(DEPTH), .PERIOD_W(16), .LDAC_W(4)) dut (
    .clk(clk), .rst(rst), .enable(enable), .period(period),
    .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data),
    .spi_start(spi_start), .spi_data(spi_data), .spi_busy(spi_busy),
    .ldac_n(ldac_n), .fifo_count(fifo_count), .underrun(underrun), .late(late),
    .flags_clr(flags_clr), .active(active)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // SPI master model plus launch/LDAC recorder, all on the falling edge.
  always @(negedge clk) begin
    if (rst) begin
      spi_busy = 1'b0;
      busy_cnt = 0;
    end else if (spi_start) begin
      spi_busy = 1'b1;
      busy_cnt = busy_len;
      start_cyc.push_back(cyc);
      start_dat.push_back(spi_data);
    end else if (busy_cnt > 0) begin
      busy_cnt--;
      if (busy_cnt == 0) spi_busy = 1'b0;
    end
    if (ldac_n === 1'b0) ldac_low++;
    else                 ldac_high++;
    if (ldac_n === 1'b0 && ldac_prev === 1'b1) fall_cyc.push_back(cyc);
    ldac_prev = ldac_n;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  task automatic push_word(input logic [15:0] d);
    s_valid = 1'b1;
    s_data  = d;
    @(negedge clk);
    s_valid = 1'b0;
  endtask

  task automatic wait_starts(input int n, input int budget, input string tag);
    int b = budget;
    while (start_cyc.size() < n && b > 0) begin
      @(negedge clk);
      b--;
    end
    chk(tag, start_cyc.size(), n);
  endtask

  task automatic clear_log();
    start_cyc.delete();
    start_dat.delete();
    fall_cyc.delete();
  endtask

  task automatic pulse_clr();
    flags_clr = 1'b1;
    @(negedge clk);
    flags_clr = 1'b0;
  endtask

  task automatic check_reset(input string tag);
    chk({tag, "_spi_start"}, spi_start, 1'b0);
    chk({tag, "_spi_data"}, spi_data, 16'h0000);
    chk({tag, "_ldac_n"}, ldac_n, LDAC_IDLE);
    chk({tag, "_underrun"}, underrun, 1'b0);
    chk({tag, "_late"}, late, 1'b0);
    chk({tag, "_active"}, active, 1'b0);
    chk({tag, "_fifo_count"}, fifo_count, 0);
    chk({tag, "_s_ready"}, s_ready, 1'b1);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    int c0, low0, hits, b;
    logic [15:0] basic_w[3] = '{16'h1234, 16'hABCD, 16'h0000};
    logic [15:0] late_w[3]  = '{16'h0F0F, 16'hF0F0, 16'h3C3C};

    rst = 1'b1; enable = 1'b0; period = 16'd100; s_valid = 1'b0; s_data = '0; flags_clr = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("init");

    // Basic rate: period 100, busy 40
    busy_len = 40; period = 16'd100; clear_log(); low0 = ldac_low;
    for (int i = 0; i < 3; i++) push_word(basic_w[i]);
    c0 = cyc; enable = 1'b1;
    wait_starts(3, 400, "basic_starts");
    repeat (50) @(negedge clk);
    enable = 1'b0;
    if (start_cyc.size() >= 3) begin
      chk("basic_latency", start_cyc[0] - c0, 101);
      chk("basic_gap1", start_cyc[1] - start_cyc[0], 100);
      chk("basic_gap2", start_cyc[2] - start_cyc[1], 100);
      for (int i = 0; i < 3; i++) chk($sformatf("basic_data%0d", i), start_dat[i], basic_w[i]);
    end
    chk("basic_underrun", underrun, 1'b0);
    chk("basic_late", late, 1'b0);
    chk("basic_fifo_count", fifo_count, 0);
`ifdef DAC_LDAC_SYNC_EN
    chk("basic_ldac_low_cycles", ldac_low - low0, 12);
    chk("basic_ldac_pulses", fall_cyc.size(), 3);
    if (fall_cyc.size() >= 3 && start_cyc.size() >= 3)
      for (int i = 0; i < 3; i++) chk($sformatf("basic_ldac_delay%0d", i), fall_cyc[i] - start_cyc[i], 41);
`else
    chk("basic_ldac_pulses", fall_cyc.size(), 0);
`endif

    // Underrun: one sample, second tick finds FIFO empty
    period = 16'd50; clear_log(); low0 = ldac_low;
    push_word(16'h5A5A);
    c0 = cyc; enable = 1'b1;
    repeat (110) @(negedge clk);
    enable = 1'b0;
    chk("underrun_starts", start_cyc.size(), 1);
    if (start_cyc.size() >= 1) begin
      chk("underrun_latency", start_cyc[0] - c0, 51);
      chk("underrun_data", start_dat[0], 16'h5A5A);
    end
    chk("underrun_flag", underrun, 1'b1);
    chk("underrun_late", late, 1'b0);
    chk("underrun_ldac_idle", ldac_n, LDAC_IDLE);
`ifdef DAC_LDAC_SYNC_EN
    chk("underrun_ldac_low_cycles", ldac_low - low0, 4);
`endif
    pulse_clr();
    chk("underrun_cleared", underrun, 1'b0);

    // Period 0 acts as 2; underrun set beats a held flags_clr
    period = 16'd0; flags_clr = 1'b1; hits = 0;
    enable = 1'b1;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (underrun) hits++;
    end
    enable = 1'b0;
    @(negedge clk);
    flags_clr = 1'b0;
    chk("setwins_hits", hits, 5);
    chk("setwins_cleared", underrun, 1'b0);

    // Late: period 20 with 30-cycle transfers
    busy_len = 30; period = 16'd20; clear_log();
    for (int i = 0; i < 3; i++) push_word(late_w[i]);
    c0 = cyc; enable = 1'b1;
    wait_starts(3, 300, "late_starts");
    repeat (40) @(negedge clk);
    enable = 1'b0;
    chk("late_flag", late, 1'b1);
    if (start_cyc.size() >= 3) begin
      chk("late_latency", start_cyc[0] - c0, 21);
      chk("late_gap1", start_cyc[1] - start_cyc[0], 40);
      chk("late_gap2", start_cyc[2] - start_cyc[1], 40);
      for (int i = 0; i < 3; i++) chk($sformatf("late_data%0d", i), start_dat[i], late_w[i]);
    end
    pulse_clr();
    chk("late_cleared", late, 1'b0);

    // FIFO full, push+pop at full, drain in order
    busy_len = 3; period = 16'd2; clear_log();
    for (int i = 0; i < DEPTH; i++) begin
      s_valid = 1'b1;
      s_data  = 16'(16'hA500 + i);
      @(negedge clk);
    end
    s_data = 16'hF00D;
    chk("full_s_ready", s_ready, 1'b0);
    chk("full_count", fifo_count, 16);
    repeat (2) @(negedge clk);
    chk("full_hold_count", fifo_count, 16);
    enable = 1'b1;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!spi_start && b < 20);
    chk("full_first_start", spi_start, 1'b1);
    chk("full_push_pop_count", fifo_count, 16);
    chk("full_push_pop_ready", s_ready, 1'b0);
    s_valid = 1'b0;
    wait_starts(17, 600, "full_starts");
    repeat (20) @(negedge clk);
    enable = 1'b0;
    if (start_cyc.size() >= 17) begin
      for (int i = 0; i < DEPTH; i++) chk($sformatf("full_data%0d", i), start_dat[i], 16'(16'hA500 + i));
      chk("full_data16", start_dat[16], 16'hF00D);
    end
    chk("full_drained_count", fifo_count, 0);
    chk("full_drained_ready", s_ready, 1'b1);
    pulse_clr();

    // Reset in the middle of a transfer
    busy_len = 30; period = 16'd10;
    for (int i = 0; i < 3; i++) push_word(late_w[i]);
    enable = 1'b1;
    b = 0;
    do begin
      @(negedge clk);
      b++;
    end while (!spi_start && b < 30);
    chk("rst_mid_start", spi_start, 1'b1);
    repeat (5) @(negedge clk);
    chk("rst_mid_active", active, 1'b1);
    rst = 1'b1; enable = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_reset("rst_mid");

`ifndef DAC_LDAC_SYNC_EN
    chk("ldac_tied_low", ldac_high, 0);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end
endmodule
